// File: rtl/rx_ctrl_pkg.sv
// Shared types and defaults for the serial receive controller.
package rx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CLR,
        RECEIVE,
        STOP_CHK,
        STOP_WAIT,
        LOAD
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 10;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter used as the half-bit counter for start-bit validation.
// Only built when RX_START_VALIDATE_EN is defined.
`ifdef RX_START_VALIDATE_EN
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= count_out + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/rx_sequencer.sv
// Receive-control FSM: sequences bit timer, stop-bit checker and RX buffer load.
// RX_START_VALIDATE_EN adds a half-bit re-check of the start bit (false-start abort).
module rx_sequencer
    import rx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_bit_detected,
    input  logic             serial_in,
    input  logic             packet_done,
    input  logic             framing_error,
    output logic             sbc_clear,
    output logic             sbc_enable,
    output logic             enable_timer,
    output logic             timer_clear,
    output logic             load_buffer,
    output logic [ERR_W-1:0] err_count
);

    rx_state_t state;
    logic      false_start;

`ifdef RX_START_VALIDATE_EN
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    // Counter parks at HALF_BIT+1 after the check so the start is tested only once per frame.
    localparam int CNT_W    = $clog2(HALF_BIT + 2);

    logic [CNT_W-1:0] half_cnt;

    flex_counter #(
        .NUM_CNT_BITS(CNT_W)
    ) u_half_bit_cnt (
        .clk         (clk),
        .n_rst       (~rst),
        .clear       (state == START_CLR),
        .count_enable((state == RECEIVE) && (half_cnt <= CNT_W'(HALF_BIT))),
        .count_out   (half_cnt)
    );

    assign false_start = (half_cnt == CNT_W'(HALF_BIT)) && serial_in;
`else
    logic unused_cfg;

    assign unused_cfg  = serial_in ^ CLKS_PER_BIT[0];
    assign false_start = 1'b0;
`endif

    // NOTE: outputs are registered from the next-state decision, so each strobe is
    // aligned with the state it belongs to and is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sbc_clear    <= 1'b0;
            sbc_enable   <= 1'b0;
            enable_timer <= 1'b0;
            timer_clear  <= 1'b0;
            load_buffer  <= 1'b0;
            err_count    <= '0;
        end else begin
            sbc_clear    <= 1'b0;
            sbc_enable   <= 1'b0;
            enable_timer <= 1'b0;
            timer_clear  <= 1'b0;
            load_buffer  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_bit_detected) begin
                        state     <= START_CLR;
                        sbc_clear <= 1'b1;
                    end
                end
                START_CLR: begin
                    state        <= RECEIVE;
                    enable_timer <= 1'b1;
                end
                RECEIVE: begin
                    if (false_start) begin
                        state       <= IDLE;
                        timer_clear <= 1'b1;
                    end else if (packet_done) begin
                        state      <= STOP_CHK;
                        sbc_enable <= 1'b1;
                    end else begin
                        enable_timer <= 1'b1;
                    end
                end
                STOP_CHK: begin
                    state <= STOP_WAIT;
                end
                STOP_WAIT: begin
                    if (framing_error) begin
                        state <= IDLE;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                    end else begin
                        state       <= LOAD;
                        load_buffer <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_sequencer.sv
// Self-checking bench for rx_sequencer; expected strobes come from the frame timing rules.
// Covers the RX_START_VALIDATE_EN build when that macro is defined.
module tb_rx_sequencer;

    localparam int CPB   = 10;
    localparam int ERR_W = 2;
    localparam int MAXE  = (1 << ERR_W) - 1;
    localparam int FS_K  = CPB / 2 + 2;
`ifdef RX_START_VALIDATE_EN
    localparam bit VALIDATE = 1'b1;
`else
    localparam bit VALIDATE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start_bit_detected;
    logic             serial_in;
    logic             packet_done;
    logic             framing_error;
    logic             sbc_clear;
    logic             sbc_enable;
    logic             enable_timer;
    logic             timer_clear;
    logic             load_buffer;
    logic [ERR_W-1:0] err_count;

    int checks    = 0;
    int errors    = 0;
    int model_err = 0;

    always #5 clk = ~clk;

    rx_sequencer #(
        .CLKS_PER_BIT(CPB),
        .ERR_W       (ERR_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start_bit_detected(start_bit_detected),
        .serial_in         (serial_in),
        .packet_done       (packet_done),
        .framing_error     (framing_error),
        .sbc_clear         (sbc_clear),
        .sbc_enable        (sbc_enable),
        .enable_timer      (enable_timer),
        .timer_clear       (timer_clear),
        .load_buffer       (load_buffer),
        .err_count         (err_count)
    );

    // Bit order: {sbc_clear, enable_timer, sbc_enable, timer_clear, load_buffer}.
    // k = cycles after the edge that sampled the start pulse; d = cycle packet_done is high.
    function automatic logic [4:0] expect_strobes(int k, int d, bit fe, bit fs);
        logic [4:0] e;
        e = '0;
        e[4] = (k == 1);
        if (fs) begin
            e[3] = (k >= 2) && (k <= FS_K);
            e[1] = (k == FS_K + 1);
        end else begin
            e[3] = (k >= 2) && (k <= d);
            e[2] = (k == d + 1);
            e[0] = !fe && (k == d + 3);
        end
        return e;
    endfunction

    // ser_mode: 0 line low; 1 line high at the half-bit check; 2 line low at the check.
    task automatic run_frame(input string name, input int d, input bit fe,
                             input bit noise, input int ser_mode);
        bit         fs;
        int         last;
        int         err_after;
        int         err_at;
        logic [4:0] exp_s;
        logic [4:0] got_s;
        int         exp_e;
        fs        = VALIDATE && (ser_mode == 1);
        last      = fs ? FS_K + 1 : (fe ? d + 3 : d + 4);
        err_after = (fe && !fs) ? ((model_err < MAXE) ? model_err + 1 : MAXE) : model_err;
        err_at    = (fe && !fs) ? d + 3 : 1 << 30;
        for (int k = 0; k < last; k++) begin
            start_bit_detected = (k == 0) || (noise && $urandom_range(0, 3) == 0);
            packet_done        = (!fs && k == d) ||
                                 (noise && (k < 2 || k > d) && $urandom_range(0, 2) == 0);
            framing_error      = (k == d + 2) ? fe : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            serial_in          = (ser_mode == 0) ? 1'b0 :
                                 (k == FS_K) ? (ser_mode == 1) : 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            exp_s = expect_strobes(k + 1, d, fe, fs);
            got_s = {sbc_clear, enable_timer, sbc_enable, timer_clear, load_buffer};
            exp_e = (k + 1 >= err_at) ? err_after : model_err;
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL %s strobes cycle %0d: got %b expected %b", name, k + 1, got_s, exp_s);
            end
            checks++;
            if (err_count !== ERR_W'(exp_e)) begin
                errors++;
                $display("FAIL %s err_count cycle %0d: got %0d expected %0d", name, k + 1, err_count, exp_e);
            end
        end
        start_bit_detected = 1'b0;
        packet_done        = 1'b0;
        framing_error      = 1'b0;
        serial_in          = 1'b0;
        model_err          = err_after;
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        start_bit_detected = 1'b0;
        serial_in          = 1'b0;
        packet_done        = 1'b0;
        framing_error      = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sbc_clear, enable_timer, sbc_enable, timer_clear, load_buffer} !== 5'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_state: strobes %b err %0d expected 00000 err 0",
                     {sbc_clear, enable_timer, sbc_enable, timer_clear, load_buffer}, err_count);
        end
        rst       = 1'b0;
        model_err = 0;
    endtask

    task automatic test_good_frame();
        run_frame("good_frame", 90, 1'b0, 1'b0, 0);
    endtask

    task automatic test_bad_stop();
        run_frame("bad_stop", int'($urandom_range(2, 40)), 1'b1, 1'b0, 0);
    endtask

    task automatic test_mid_frame_reset();
        start_bit_detected = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_bit_detected = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (enable_timer !== 1'b1 || err_count !== ERR_W'(model_err)) begin
            errors++;
            $display("FAIL pre_reset_receive: enable_timer %b err %0d expected 1 err %0d",
                     enable_timer, err_count, model_err);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sbc_clear, enable_timer, sbc_enable, timer_clear, load_buffer} !== 5'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL mid_frame_reset: strobes %b err %0d expected 00000 err 0",
                     {sbc_clear, enable_timer, sbc_enable, timer_clear, load_buffer}, err_count);
        end
        @(negedge clk);
        rst       = 1'b0;
        model_err = 0;
        run_frame("after_reset", int'($urandom_range(2, 30)), 1'b0, 1'b0, 0);
    endtask

    task automatic test_saturation();
        int table_e [5] = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            run_frame("saturation", int'($urandom_range(2, 20)), 1'b1, 1'b0, 0);
            checks++;
            if (err_count !== ERR_W'(table_e[i])) begin
                errors++;
                $display("FAIL saturation frame %0d: err %0d expected %0d", i, err_count, table_e[i]);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        for (int i = 0; i < 20; i++) begin
            packet_done   = 1'($urandom_range(0, 1));
            framing_error = 1'($urandom_range(0, 1));
            serial_in     = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({sbc_clear, enable_timer, sbc_enable, timer_clear, load_buffer} !== 5'b0 ||
                err_count !== ERR_W'(model_err)) begin
                errors++;
                $display("FAIL idle_ignore cycle %0d: strobes %b err %0d expected 00000 err %0d", i,
                         {sbc_clear, enable_timer, sbc_enable, timer_clear, load_buffer}, err_count, model_err);
            end
        end
        packet_done   = 1'b0;
        framing_error = 1'b0;
        serial_in     = 1'b0;
        run_frame("busy_ignore", int'($urandom_range(10, 40)), 1'b0, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            run_frame("back_to_back", int'($urandom_range(2, 60)), 1'($urandom_range(0, 1)), 1'b1, 0);
        end
    endtask

    task automatic test_start_validate();
        run_frame("false_start", int'($urandom_range(10, 60)), 1'b0, 1'b0, 1);
        run_frame("valid_start", int'($urandom_range(10, 60)), 1'b0, 1'b0, 2);
        run_frame("false_start_b2b", int'($urandom_range(10, 60)), 1'b1, 1'b1, 1);
        run_frame("valid_start_bad", int'($urandom_range(10, 60)), 1'b1, 1'b1, 2);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_stop();
        test_mid_frame_reset();
        test_saturation();
        test_ignored_inputs();
        test_back_to_back();
        test_start_validate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
